// File: rtl/weight_fetch_controller.sv
// ---------------------------------------------------------------------------
// weight_fetch_controller
//
// Sequences binary-weight fetches from the weight SRAM into the PE array's
// weight registers for one convolution layer. Each SRAM word carries one
// weight bit per PE column (one filter per column) for a single
// (channel, ky, kx) position. The walk order is filter group -> input
// channel -> kernel position; between channels the block parks in WAIT
// until the ifmap side pulses advance.
//
// Ports
//   clk             in   rising-edge clock
//   rst             in   asynchronous, active-low reset
//   start           in   1-cycle layer start pulse, accepted only when idle
//   weight_base     in   first weight word address of the layer
//   number_channel  in   input channels C (0 = empty layer)
//   kernel_size     in   square kernel size K (0 = empty layer)
//   number_filter   in   output filters F (0 = empty layer)
//   advance         in   1-cycle pulse: current channel's weights consumed
//   address_weight  out  SRAM read address
//   weight_rd_en    out  SRAM read strobe
//   weight_load     out  PE weight-register capture strobe (rd_en + 1 cycle)
//   kpos            out  kernel position of the word captured on weight_load
//   pe_col_en       out  active-column mask of the current filter group
//   first_channel   out  fetching/holding channel 0
//   last_channel    out  fetching/holding channel C-1
//   busy            out  layer in progress
//   done            out  1-cycle pulse at layer end
//   overrun         out  (only with WEIGHT_FETCH_OVERRUN_EN) sticky flag for
//                        an advance that could not be queued
//
// Build option: define WEIGHT_FETCH_OVERRUN_EN to add the overrun output.
// Without it, surplus advance pulses are dropped silently.
//
// PE_COLS is expected to be a power of two: group index and column remainder
// are taken from the filter count with a shift and a mask.
// ---------------------------------------------------------------------------
module weight_fetch_controller #(
    parameter int ADDR_W  = 16,
    parameter int PE_COLS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   weight_base,
    input  logic [5:0]          number_channel,
    input  logic [3:0]          kernel_size,
    input  logic [6:0]          number_filter,
    input  logic                advance,
    output logic [ADDR_W-1:0]   address_weight,
    output logic                weight_rd_en,
    output logic                weight_load,
    output logic [7:0]          kpos,
    output logic [PE_COLS-1:0]  pe_col_en,
    output logic                first_channel,
    output logic                last_channel,
    output logic                busy,
    output logic                done
`ifdef WEIGHT_FETCH_OVERRUN_EN
    ,
    output logic                overrun
`endif
);

    localparam int COL_W = $clog2(PE_COLS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Column mask of a filter group: every column is live except in the last
    // group when F is not a multiple of PE_COLS.
    function automatic logic [PE_COLS-1:0] group_col_mask(
        input logic [6:0] filters,
        input logic [6:0] group
    );
        logic [6:0] rem_v;
        logic [6:0] last_grp_v;
        rem_v      = filters & 7'(PE_COLS - 1);
        last_grp_v = (filters - 7'd1) >> COL_W;
        if ((group == last_grp_v) && (rem_v != 7'd0)) begin
            group_col_mask = ~({PE_COLS{1'b1}} << rem_v);
        end else begin
            group_col_mask = {PE_COLS{1'b1}};
        end
    endfunction

    state_t              state_r,   state_next_s;
    logic [5:0]          c_r;
    logic [3:0]          k_r;
    logic [6:0]          f_r;
    logic [5:0]          ch_r,      ch_next_s;
    logic [6:0]          grp_r,     grp_next_s;
    logic [3:0]          kx_r,      kx_next_s;
    logic [3:0]          ky_r,      ky_next_s;
    logic [7:0]          kcnt_r,    kcnt_next_s;
    logic                pending_r, pending_next_s;
    logic [ADDR_W-1:0]   addr_r,    addr_next_s;
    logic [5:0]          cfg_c_s;
    logic [6:0]          cfg_f_s;
    logic [6:0]          last_grp_s;
    logic                active_s;

    logic                rd_en_r;
    logic                load_r;
    logic [7:0]          kpos_r;
    logic [PE_COLS-1:0]  pe_r;
    logic                first_r;
    logic                last_r;
    logic                busy_r;
    logic                done_r;

    assign last_grp_s = (f_r - 7'd1) >> COL_W;

    // Next-state and counter logic. The address advances on every read after
    // the first of a channel, and on the WAIT->FETCH hop, so it stays parked
    // on the last word read while waiting (plain base + running count).
    always_comb begin
        state_next_s   = state_r;
        ch_next_s      = ch_r;
        grp_next_s     = grp_r;
        kx_next_s      = kx_r;
        ky_next_s      = ky_r;
        kcnt_next_s    = kcnt_r;
        pending_next_s = pending_r;
        addr_next_s    = addr_r;
        cfg_c_s        = c_r;
        cfg_f_s        = f_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    // Config is not latched yet; derive next-cycle outputs from the ports.
                    cfg_c_s        = number_channel;
                    cfg_f_s        = number_filter;
                    addr_next_s    = weight_base;
                    ch_next_s      = 6'd0;
                    grp_next_s     = 7'd0;
                    kx_next_s      = 4'd0;
                    ky_next_s      = 4'd0;
                    kcnt_next_s    = 8'd0;
                    pending_next_s = 1'b0;
                    if ((number_channel == 6'd0) || (kernel_size == 4'd0) ||
                        (number_filter == 7'd0)) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // One-deep memory of an advance that arrives before WAIT.
                if (advance) begin
                    pending_next_s = 1'b1;
                end else begin
                    pending_next_s = pending_r;
                end
                if ((kx_r == k_r - 4'd1) && (ky_r == k_r - 4'd1)) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_FETCH;
                    addr_next_s  = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    kcnt_next_s  = kcnt_r + 8'd1;
                    if (kx_r == k_r - 4'd1) begin
                        kx_next_s = 4'd0;
                        ky_next_s = ky_r + 4'd1;
                    end else begin
                        kx_next_s = kx_r + 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (advance || pending_r) begin
                    pending_next_s = 1'b0;
                    kx_next_s      = 4'd0;
                    ky_next_s      = 4'd0;
                    kcnt_next_s    = 8'd0;
                    if (ch_r != c_r - 6'd1) begin
                        ch_next_s    = ch_r + 6'd1;
                        state_next_s = ST_FETCH;
                        addr_next_s  = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end else if (grp_r != last_grp_s) begin
                        grp_next_s   = grp_r + 7'd1;
                        ch_next_s    = 6'd0;
                        state_next_s = ST_FETCH;
                        addr_next_s  = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    assign active_s = (state_next_s == ST_FETCH) || (state_next_s == ST_WAIT);

    // State, walk counters, address and latched layer configuration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            c_r       <= 6'd0;
            k_r       <= 4'd0;
            f_r       <= 7'd0;
            ch_r      <= 6'd0;
            grp_r     <= 7'd0;
            kx_r      <= 4'd0;
            ky_r      <= 4'd0;
            kcnt_r    <= 8'd0;
            pending_r <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
        end else begin
            state_r   <= state_next_s;
            ch_r      <= ch_next_s;
            grp_r     <= grp_next_s;
            kx_r      <= kx_next_s;
            ky_r      <= ky_next_s;
            kcnt_r    <= kcnt_next_s;
            pending_r <= pending_next_s;
            addr_r    <= addr_next_s;
            if ((state_r == ST_IDLE) && start) begin
                c_r <= number_channel;
                k_r <= kernel_size;
                f_r <= number_filter;
            end else begin
                c_r <= c_r;
                k_r <= k_r;
                f_r <= f_r;
            end
        end
    end

    // Registered outputs, computed from the state being entered so they line
    // up with state_r. busy stays up through the done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en_r <= 1'b0;
            load_r  <= 1'b0;
            kpos_r  <= 8'd0;
            pe_r    <= {PE_COLS{1'b0}};
            first_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            rd_en_r <= (state_next_s == ST_FETCH);
            load_r  <= rd_en_r;
            if (rd_en_r) begin
                kpos_r <= kcnt_r;
            end else begin
                kpos_r <= kpos_r;
            end
            if (active_s) begin
                pe_r <= group_col_mask(cfg_f_s, grp_next_s);
            end else begin
                pe_r <= {PE_COLS{1'b0}};
            end
            first_r <= active_s && (ch_next_s == 6'd0);
            last_r  <= active_s && (ch_next_s == cfg_c_s - 6'd1);
            busy_r  <= (state_next_s != ST_IDLE) || (state_r == ST_DONE);
            done_r  <= (state_r == ST_DONE);
        end
    end

    assign address_weight = addr_r;
    assign weight_rd_en   = rd_en_r;
    assign weight_load    = load_r;
    assign kpos           = kpos_r;
    assign pe_col_en      = pe_r;
    assign first_channel  = first_r;
    assign last_channel   = last_r;
    assign busy           = busy_r;
    assign done           = done_r;

`ifdef WEIGHT_FETCH_OVERRUN_EN
    logic overrun_r;
    logic overrun_set_s;

    // An advance is lost if one is already queued or no layer is running.
    assign overrun_set_s = advance &&
                           (pending_r || (state_r == ST_IDLE) || (state_r == ST_DONE));

    // Sticky overrun flag, cleared by an accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_r <= 1'b0;
        end else if (overrun_set_s) begin
            overrun_r <= 1'b1;
        end else if ((state_r == ST_IDLE) && start) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign overrun = overrun_r;
`endif

endmodule

// File: tb/tb_weight_fetch_controller.sv
// Testbench for weight_fetch_controller: directed layers plus randomized
// layers, each checked against a read list built from the walk order
// (group -> channel -> kernel position) and a cycle budget derived from the
// advance timing the bench itself chooses.
module tb_weight_fetch_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] weight_base;
    logic [5:0]  number_channel;
    logic [3:0]  kernel_size;
    logic [6:0]  number_filter;
    logic        advance;
    logic [15:0] address_weight;
    logic        weight_rd_en;
    logic        weight_load;
    logic [7:0]  kpos;
    logic [31:0] pe_col_en;
    logic        first_channel;
    logic        last_channel;
    logic        busy;
    logic        done;
`ifdef WEIGHT_FETCH_OVERRUN_EN
    logic        overrun;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  kpos;
        logic [31:0] mask;
        logic        first;
        logic        last;
    } rd_t;

    rd_t exp_q[$];

    always #5 clk = ~clk;

    weight_fetch_controller #(.ADDR_W(16), .PE_COLS(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .weight_base    (weight_base),
        .number_channel (number_channel),
        .kernel_size    (kernel_size),
        .number_filter  (number_filter),
        .advance        (advance),
        .address_weight (address_weight),
        .weight_rd_en   (weight_rd_en),
        .weight_load    (weight_load),
        .kpos           (kpos),
        .pe_col_en      (pe_col_en),
        .first_channel  (first_channel),
        .last_channel   (last_channel),
        .busy           (busy),
        .done           (done)
`ifdef WEIGHT_FETCH_OVERRUN_EN
        ,
        .overrun        (overrun)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic any_output_high();
        return |{address_weight, weight_rd_en, weight_load, kpos, pe_col_en,
                 first_channel, last_channel, busy, done};
    endfunction

    // Run one layer. mode 0: advance 'delay' cycles into each WAIT
    // (delay < 0 picks a random delay per WAIT); mode 1: advance on the first
    // read of each burst so it is already pending at WAIT entry.
    // glitch: pulse start with different config while the layer is busy.
    task automatic run_layer(input logic [15:0] base, input int c, input int k, input int f,
                             input int mode, input int delay, input bit glitch);
        int   g_n, lin, cyc, wait_total, adv_cnt, busy_cnt, done_cyc, d, exp_done;
        logic prev_rd;
        logic [7:0] last_kpos;
        rd_t  e;
        rd_t  rd;
        exp_q.delete();
        g_n = (f + 31) / 32;
        lin = 0;
        for (int g = 0; g < g_n; g++) begin
            for (int ch = 0; ch < c; ch++) begin
                for (int p = 0; p < k * k; p++) begin
                    e.addr  = base + 16'(lin);
                    e.kpos  = 8'(p);
                    e.mask  = ((g == g_n - 1) && (f % 32 != 0)) ?
                              32'((64'd1 << (f % 32)) - 64'd1) : 32'hFFFF_FFFF;
                    e.first = (ch == 0);
                    e.last  = (ch == c - 1);
                    exp_q.push_back(e);
                    lin++;
                end
            end
        end
        weight_base    = base;
        number_channel = 6'(c);
        kernel_size    = 4'(k);
        number_filter  = 7'(f);
        start          = 1'b1;
        cyc = 0; wait_total = 0; adv_cnt = -1; busy_cnt = 0; done_cyc = -1;
        prev_rd = 1'b0; last_kpos = 8'd0;
        while ((done_cyc < 0) && (cyc < 20000)) begin
            @(negedge clk);
            cyc++;
            start   = 1'b0;
            advance = 1'b0;
            if (busy) busy_cnt++;
            if (done) done_cyc = cyc;
            check("weight_load", weight_load, prev_rd);
            if (weight_load && prev_rd) check("kpos", kpos, last_kpos);
            if (weight_rd_en) begin
                if (exp_q.size() == 0) begin
                    check("extra_read", weight_rd_en, 1'b0);
                end else begin
                    rd = exp_q.pop_front();
                    check("address", address_weight, rd.addr);
                    check("pe_col_en", pe_col_en, rd.mask);
                    check("first_channel", first_channel, rd.first);
                    check("last_channel", last_channel, rd.last);
                    last_kpos = rd.kpos;
                    if ((mode == 1) && (rd.kpos == 8'd0)) advance = 1'b1;
                end
            end else if (prev_rd) begin
                if (mode == 1) begin
                    wait_total += 1;
                end else begin
                    d = (delay < 0) ? int'($urandom_range(0, 3)) : delay;
                    adv_cnt = d;
                    wait_total += d + 1;
                end
            end
            if (adv_cnt == 0) begin
                advance = 1'b1;
                adv_cnt = -1;
            end else if (adv_cnt > 0) begin
                adv_cnt--;
            end
            if (glitch && (cyc == 3)) begin
                start          = 1'b1;
                weight_base    = ~base;
                number_channel = 6'd1;
                kernel_size    = 4'd1;
                number_filter  = 7'd1;
            end
            prev_rd = weight_rd_en;
        end
        exp_done = g_n * c * k * k + wait_total + 2;
        check("done_cycle", done_cyc, exp_done);
        check("reads_left", exp_q.size(), 0);
        check("busy_cycles", busy_cnt, exp_done);
        @(negedge clk);
        check("post_done_idle", {busy, done, first_channel, last_channel}, 4'd0);
        check("post_done_pe", pe_col_en, 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; advance = 1'b0;
        weight_base = 16'd0; number_channel = 6'd0; kernel_size = 4'd0; number_filter = 7'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs", any_output_high(), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_outputs", any_output_high(), 1'b0);

        // Two channels of 3x3, advance 5 cycles into each WAIT.
        run_layer(16'h0100, 2, 3, 32, 0, 5, 1'b0);
        // Two filter groups, partial last group.
        run_layer(16'h0000, 1, 1, 40, 1, 0, 1'b0);
        // Empty layers: C, K or F zero.
        run_layer(16'($urandom), 0, 3, 17, 0, 0, 1'b0);
        run_layer(16'h0040, 3, 0, 5, 0, 0, 1'b0);
        run_layer(16'h0040, 3, 2, 0, 0, 0, 1'b0);
        // Advance arrives mid-FETCH: WAIT lasts exactly one cycle.
        run_layer(16'h0300, 2, 2, 32, 1, 0, 1'b0);

        // Reset in the middle of a burst.
        weight_base = 16'h0200; number_channel = 6'd1; kernel_size = 4'd3; number_filter = 7'd32;
        start = 1'b1;
        n = 0;
        for (int i = 0; (i < 50) && (n < 4); i++) begin
            @(negedge clk);
            start = 1'b0;
            if (weight_rd_en) n++;
        end
        check("reads_before_rst", n, 4);
        rst = 1'b0;
        #1;
        check("async_rst_outputs", any_output_high(), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_layer(16'h0200, 1, 3, 32, 0, 1, 1'b0);

        // Address wrap at the top of the space.
        run_layer(16'hFFFE, 1, 2, 1, 0, 2, 1'b0);

        // Advance while idle is ignored; start while busy is ignored.
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        run_layer(16'h1234, 2, 3, 64, 0, -1, 1'b1);

`ifdef WEIGHT_FETCH_OVERRUN_EN
        // Two advances inside one FETCH burst raise the sticky flag.
        weight_base = 16'h0000; number_channel = 6'd1; kernel_size = 4'd4; number_filter = 7'd1;
        start = 1'b1;
        n = 0;
        for (int i = 0; (i < 100) && !done; i++) begin
            @(negedge clk);
            start   = 1'b0;
            advance = 1'b0;
            if (weight_rd_en && (n < 2)) begin
                advance = 1'b1;
                n++;
            end
        end
        check("overrun_done_seen", done, 1'b1);
        check("overrun_set", overrun, 1'b1);
        @(negedge clk);
        check("overrun_sticky", overrun, 1'b1);
        run_layer(16'h0010, 1, 1, 1, 1, 0, 1'b0);
        check("overrun_cleared", overrun, 1'b0);
`endif

        // Randomized layers.
        for (int t = 0; t < 6; t++) begin
            run_layer(16'($urandom), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                      int'($urandom_range(1, 127)), int'($urandom_range(0, 1)), -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
